// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB with a
// memory-ready handshake, a per-access wait timeout, sticky fault and retire count.
module mc_controller #(
  parameter int OPCODE_WIDTH   = 6,
  parameter int MEM_WAIT_MAX   = 15,
  parameter int WAIT_CNT_WIDTH = 4,
  parameter int RETIRE_WIDTH   = 16
) (
  input  logic                    mc_clk,
  input  logic                    mc_rst,
  input  logic                    mc_i_ce,
  input  logic [OPCODE_WIDTH-1:0] mc_i_opcode,
  input  logic                    mc_i_mem_ready,
  output logic                    mc_o_PCWrite,
  output logic                    mc_o_Branch,
  output logic                    mc_o_IorD,
  output logic                    mc_o_MemRead,
  output logic                    mc_o_MemWrite,
  output logic                    mc_o_IRWrite,
  output logic                    mc_o_MemtoReg,
  output logic                    mc_o_RegDst,
  output logic                    mc_o_RegWrite,
  output logic                    mc_o_ALUSrcA,
  output logic [1:0]              mc_o_ALUSrcB,
  output logic [1:0]              mc_o_ALUOp,
  output logic [1:0]              mc_o_PCSrc,
  output logic [3:0]              mc_o_state,
  output logic                    mc_o_fault,
  output logic                    mc_o_instr_done,
  output logic [RETIRE_WIDTH-1:0] mc_o_retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12, S_FAULT  = 4'd15
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
  localparam logic [WAIT_CNT_WIDTH:0] WAIT_LAST = (WAIT_CNT_WIDTH+1)'(MEM_WAIT_MAX);
  localparam logic [WAIT_CNT_WIDTH:0] WAIT_ONE  = (WAIT_CNT_WIDTH+1)'(1);

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [OPCODE_WIDTH-1:0]   opcode_q, opcode_d;
  logic [RETIRE_WIDTH-1:0]   retired_q, retired_d;
  logic                      fault_q, fault_d;
  logic                      is_wait, timeout;

  always_ff @(posedge mc_clk or negedge mc_rst) begin
    if (!mc_rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      retired_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      opcode_q   <= opcode_d;
      retired_q  <= retired_d;
      fault_q    <= fault_d;
    end
  end

  // Timeout fires on the cycle whose miss would bring the count to MEM_WAIT_MAX.
  always_comb begin
    is_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout = (MEM_WAIT_MAX != 0) && !mc_i_mem_ready &&
              (({1'b0, wait_cnt_q} + WAIT_ONE) == WAIT_LAST);
  end

  always_comb begin
    state_d = state_q;
    if (mc_i_ce) begin
      case (state_q)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH:  if (mc_i_mem_ready) state_d = S_DECODE;
                  else if (timeout)   state_d = S_FAULT;
        S_DECODE: begin
          case (mc_i_opcode)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_FAULT;
          endcase
        end
        S_MEMADR: state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mc_i_mem_ready) state_d = S_MEMWB;
                  else if (timeout)   state_d = S_FAULT;
        S_MEMWR:  if (mc_i_mem_ready) state_d = S_FETCH;
                  else if (timeout)   state_d = S_FAULT;
        S_EXEC:   state_d = S_ALUWB;
        S_ADDIEX: state_d = S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
        S_FAULT:  state_d = S_FAULT;
        default:  state_d = S_FAULT;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    opcode_d   = opcode_q;
    retired_d  = retired_q;
    fault_d    = fault_q;
    if (mc_i_ce) begin
      if (state_d != state_q)             wait_cnt_d = '0;
      else if (is_wait && !mc_i_mem_ready) wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
      if (state_q == S_DECODE) opcode_d  = mc_i_opcode;
      if (mc_o_instr_done)     retired_d = retired_q + RETIRE_WIDTH'(1);
      if (state_d == S_FAULT)  fault_d   = 1'b1;
    end
  end

  always_comb begin
    mc_o_PCWrite    = 1'b0;
    mc_o_Branch     = 1'b0;
    mc_o_IorD       = 1'b0;
    mc_o_MemRead    = 1'b0;
    mc_o_MemWrite   = 1'b0;
    mc_o_IRWrite    = 1'b0;
    mc_o_MemtoReg   = 1'b0;
    mc_o_RegDst     = 1'b0;
    mc_o_RegWrite   = 1'b0;
    mc_o_ALUSrcA    = 1'b0;
    mc_o_ALUSrcB    = 2'b00;
    mc_o_ALUOp      = 2'b00;
    mc_o_PCSrc      = 2'b00;
    mc_o_instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mc_o_MemRead = 1'b1;
        mc_o_ALUSrcB = 2'b01;
        mc_o_IRWrite = mc_i_mem_ready;
        mc_o_PCWrite = mc_i_mem_ready;
      end
      S_DECODE: mc_o_ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        mc_o_ALUSrcA = 1'b1;
        mc_o_ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mc_o_IorD    = 1'b1;
        mc_o_MemRead = 1'b1;
      end
      S_MEMWB: begin
        mc_o_MemtoReg   = 1'b1;
        mc_o_RegWrite   = 1'b1;
        mc_o_instr_done = 1'b1;
      end
      S_MEMWR: begin
        mc_o_IorD       = 1'b1;
        mc_o_MemWrite   = 1'b1;
        mc_o_instr_done = mc_i_mem_ready;
      end
      S_EXEC: begin
        mc_o_ALUSrcA = 1'b1;
        mc_o_ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        mc_o_RegDst     = 1'b1;
        mc_o_RegWrite   = 1'b1;
        mc_o_instr_done = 1'b1;
      end
      S_BRANCH: begin
        mc_o_ALUSrcA    = 1'b1;
        mc_o_ALUOp      = 2'b01;
        mc_o_Branch     = 1'b1;
        mc_o_PCSrc      = 2'b01;
        mc_o_instr_done = 1'b1;
      end
      S_ADDIWB: begin
        mc_o_RegWrite   = 1'b1;
        mc_o_instr_done = 1'b1;
      end
      S_JUMP: begin
        mc_o_PCSrc      = 2'b10;
        mc_o_PCWrite    = 1'b1;
        mc_o_instr_done = 1'b1;
      end
      default: ;
    endcase
    // Side-effecting strobes are suppressed while frozen; mux selects are left alone.
    if (!mc_i_ce) begin
      mc_o_PCWrite    = 1'b0;
      mc_o_Branch     = 1'b0;
      mc_o_IRWrite    = 1'b0;
      mc_o_RegWrite   = 1'b0;
      mc_o_MemWrite   = 1'b0;
      mc_o_instr_done = 1'b0;
    end
  end

  assign mc_o_state   = state_q;
  assign mc_o_fault   = fault_q;
  assign mc_o_retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues expected retire records,
// a negedge monitor pops one on every instr_done pulse.
module tb_mc_controller;
  logic       mc_clk = 1'b0;
  logic       mc_rst = 1'b1;
  logic       mc_i_ce = 1'b0;
  logic       mc_i_mem_ready = 1'b0;
  logic [5:0] mc_i_opcode = '0;

  logic        mc_o_PCWrite, mc_o_Branch, mc_o_IorD, mc_o_MemRead, mc_o_MemWrite;
  logic        mc_o_IRWrite, mc_o_MemtoReg, mc_o_RegDst, mc_o_RegWrite, mc_o_ALUSrcA;
  logic [1:0]  mc_o_ALUSrcB, mc_o_ALUOp, mc_o_PCSrc;
  logic [3:0]  mc_o_state;
  logic        mc_o_fault, mc_o_instr_done;
  logic [15:0] mc_o_retired;

  logic        r2_PCWrite, r2_Branch, r2_IorD, r2_MemRead, r2_MemWrite;
  logic        r2_IRWrite, r2_MemtoReg, r2_RegDst, r2_RegWrite, r2_ALUSrcA;
  logic [1:0]  r2_ALUSrcB, r2_ALUOp, r2_PCSrc;
  logic [3:0]  r2_state;
  logic        r2_fault, r2_instr_done;
  logic [1:0]  r2_retired;

  mc_controller dut (
    .mc_clk(mc_clk), .mc_rst(mc_rst), .mc_i_ce(mc_i_ce), .mc_i_opcode(mc_i_opcode),
    .mc_i_mem_ready(mc_i_mem_ready), .mc_o_PCWrite(mc_o_PCWrite), .mc_o_Branch(mc_o_Branch),
    .mc_o_IorD(mc_o_IorD), .mc_o_MemRead(mc_o_MemRead), .mc_o_MemWrite(mc_o_MemWrite),
    .mc_o_IRWrite(mc_o_IRWrite), .mc_o_MemtoReg(mc_o_MemtoReg), .mc_o_RegDst(mc_o_RegDst),
    .mc_o_RegWrite(mc_o_RegWrite), .mc_o_ALUSrcA(mc_o_ALUSrcA), .mc_o_ALUSrcB(mc_o_ALUSrcB),
    .mc_o_ALUOp(mc_o_ALUOp), .mc_o_PCSrc(mc_o_PCSrc), .mc_o_state(mc_o_state),
    .mc_o_fault(mc_o_fault), .mc_o_instr_done(mc_o_instr_done), .mc_o_retired(mc_o_retired)
  );

  mc_controller #(.RETIRE_WIDTH(2)) dut_r2 (
    .mc_clk(mc_clk), .mc_rst(mc_rst), .mc_i_ce(mc_i_ce), .mc_i_opcode(mc_i_opcode),
    .mc_i_mem_ready(mc_i_mem_ready), .mc_o_PCWrite(r2_PCWrite), .mc_o_Branch(r2_Branch),
    .mc_o_IorD(r2_IorD), .mc_o_MemRead(r2_MemRead), .mc_o_MemWrite(r2_MemWrite),
    .mc_o_IRWrite(r2_IRWrite), .mc_o_MemtoReg(r2_MemtoReg), .mc_o_RegDst(r2_RegDst),
    .mc_o_RegWrite(r2_RegWrite), .mc_o_ALUSrcA(r2_ALUSrcA), .mc_o_ALUSrcB(r2_ALUSrcB),
    .mc_o_ALUOp(r2_ALUOp), .mc_o_PCSrc(r2_PCSrc), .mc_o_state(r2_state),
    .mc_o_fault(r2_fault), .mc_o_instr_done(r2_instr_done), .mc_o_retired(r2_retired)
  );

  always #5 mc_clk = ~mc_clk;

  typedef struct {
    int st;
    int ctl;   // {RegWrite,MemtoReg,RegDst,PCWrite,Branch,MemWrite,PCSrc[1:0]}
    int ret;   // retired count before this retire
    bit c2;
    int r2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int st, input int ctl, input int ret, input bit c2, input int r2);
    exp_t e;
    e.st = st; e.ctl = ctl; e.ret = ret; e.c2 = c2; e.r2 = r2;
    exp_q.push_back(e);
  endtask

  always @(negedge mc_clk) begin
    if (mc_rst && mc_o_instr_done) begin
      if (exp_q.size() == 0) chk("unexpected_retire", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("retire_state", int'(mc_o_state), mon_e.st);
        chk("retire_ctl", int'({mc_o_RegWrite, mc_o_MemtoReg, mc_o_RegDst, mc_o_PCWrite,
                                mc_o_Branch, mc_o_MemWrite, mc_o_PCSrc}), mon_e.ctl);
        chk("retire_count", int'(mc_o_retired), mon_e.ret);
        if (mon_e.c2) chk("retire_count_w2", int'(r2_retired), mon_e.r2);
      end
    end
  end

  task automatic cyc();
    @(posedge mc_clk);
    #1;
  endtask

  task automatic do_reset();
    chk("queue_empty_before_reset", exp_q.size(), 0);
    mc_rst = 1'b0; mc_i_ce = 1'b0; mc_i_mem_ready = 1'b0; mc_i_opcode = '0;
    #1;
    chk("rst_state", int'(mc_o_state), 0);
    chk("rst_fault", int'(mc_o_fault), 0);
    chk("rst_retired", int'(mc_o_retired), 0);
    chk("rst_strobes", int'({mc_o_PCWrite, mc_o_MemRead, mc_o_RegWrite, mc_o_instr_done}), 0);
    cyc();
    mc_rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // R-type, ready always high: 0,1,2,7,8,1
    mc_i_ce = 1'b1; mc_i_mem_ready = 1'b1; mc_i_opcode = 6'b000000;
    #1;
    chk("t1_idle", int'(mc_o_state), 0);
    cyc(); chk("t1_fetch", int'(mc_o_state), 1);
    chk("t1_fetch_irw_pcw_rd", int'({mc_o_IRWrite, mc_o_PCWrite, mc_o_MemRead}), 7);
    cyc(); chk("t1_decode", int'(mc_o_state), 2);
    chk("t1_decode_srcb", int'(mc_o_ALUSrcB), 3);
    cyc(); chk("t1_exec", int'(mc_o_state), 7);
    chk("t1_exec_aluop", int'({mc_o_ALUSrcA, mc_o_ALUOp}), 3'b110);
    push(8, 8'b1010_0000, 0, 1'b0, 0);
    cyc(); chk("t1_aluwb", int'(mc_o_state), 8);
    cyc(); chk("t1_back_fetch", int'(mc_o_state), 1);
    chk("t1_retired", int'(mc_o_retired), 1);

    // lw with 3 not-ready cycles in MEMRD
    mc_i_opcode = 6'b100011;
    cyc(); chk("t2_decode", int'(mc_o_state), 2);
    cyc(); chk("t2_memadr", int'(mc_o_state), 3);
    chk("t2_memadr_srcb", int'(mc_o_ALUSrcB), 2);
    mc_i_mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("t2_memrd_wait", int'(mc_o_state), 4);
      chk("t2_memrd_rd_iord", int'({mc_o_MemRead, mc_o_IorD}), 3);
      cyc();
    end
    mc_i_mem_ready = 1'b1; #1;
    chk("t2_memrd_last", int'(mc_o_state), 4);
    push(5, 8'b1100_0000, 1, 1'b0, 0);
    cyc(); chk("t2_memwb", int'(mc_o_state), 5);
    cyc(); chk("t2_fetch", int'(mc_o_state), 1);
    chk("t2_retired", int'(mc_o_retired), 2);

    // sw, ready never comes: fault after 15 MEMWR cycles
    mc_i_opcode = 6'b101011;
    cyc(); cyc(); chk("t3_memadr", int'(mc_o_state), 3);
    mc_i_mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 15; i++) begin
      chk("t3_memwr_wait", int'(mc_o_state), 6);
      cyc();
    end
    chk("t3_fault_state", int'(mc_o_state), 15);
    chk("t3_fault_flag", int'(mc_o_fault), 1);
    chk("t3_fault_memwrite", int'(mc_o_MemWrite), 0);
    mc_i_mem_ready = 1'b1;
    cyc(); cyc();
    chk("t3_fault_absorbing", int'(mc_o_state), 15);
    chk("t3_fault_retired", int'(mc_o_retired), 2);

    // sw, ready exactly on the 15th MEMWR cycle: no fault
    do_reset();
    mc_i_ce = 1'b1; mc_i_mem_ready = 1'b1; mc_i_opcode = 6'b101011;
    cyc(); cyc(); cyc(); chk("t3b_memadr", int'(mc_o_state), 3);
    mc_i_mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 14; i++) begin
      chk("t3b_memwr_wait", int'(mc_o_state), 6);
      cyc();
    end
    mc_i_mem_ready = 1'b1; #1;
    chk("t3b_memwr_15th", int'(mc_o_state), 6);
    push(6, 8'b0000_0100, 0, 1'b0, 0);
    cyc(); chk("t3b_fetch", int'(mc_o_state), 1);
    chk("t3b_no_fault", int'(mc_o_fault), 0);
    chk("t3b_retired", int'(mc_o_retired), 1);

    // illegal opcode, then async reset in FAULT
    mc_i_opcode = 6'b111111;
    cyc(); chk("t4_decode", int'(mc_o_state), 2);
    cyc(); chk("t4_fault", int'(mc_o_state), 15);
    chk("t4_fault_flag", int'(mc_o_fault), 1);
    #2 mc_rst = 1'b0;
    #1;
    chk("t4_async_state", int'(mc_o_state), 0);
    chk("t4_async_fault", int'(mc_o_fault), 0);
    chk("t4_async_retired", int'(mc_o_retired), 0);
    @(posedge mc_clk); #1;
    mc_rst = 1'b1;

    // addi with ce low in FETCH and in ADDIEX
    mc_i_opcode = 6'b001000;
    cyc(); chk("t5_fetch", int'(mc_o_state), 1);
    mc_i_ce = 1'b0; #1;
    chk("t5_fetch_frozen_strobes", int'({mc_o_IRWrite, mc_o_PCWrite, mc_o_MemRead}), 1);
    cyc(); chk("t5_fetch_hold", int'(mc_o_state), 1);
    mc_i_ce = 1'b1;
    cyc(); chk("t5_decode", int'(mc_o_state), 2);
    cyc(); chk("t5_addiex", int'(mc_o_state), 10);
    mc_i_ce = 1'b0; #1;
    chk("t5_frozen_regwrite", int'(mc_o_RegWrite), 0);
    chk("t5_frozen_srcb", int'(mc_o_ALUSrcB), 2);
    cyc(); chk("t5_hold1", int'(mc_o_state), 10);
    cyc(); chk("t5_hold2", int'(mc_o_state), 10);
    chk("t5_hold_regwrite", int'(mc_o_RegWrite), 0);
    chk("t5_hold_retired", int'(mc_o_retired), 0);
    mc_i_ce = 1'b1;
    push(11, 8'b1000_0000, 0, 1'b0, 0);
    cyc(); chk("t5_addiwb", int'(mc_o_state), 11);
    cyc(); chk("t5_fetch_after", int'(mc_o_state), 1);
    chk("t5_retired", int'(mc_o_retired), 1);

    // five jumps, 2-bit retire counter wraps 1,2,3,0,1
    do_reset();
    mc_i_ce = 1'b1; mc_i_mem_ready = 1'b1; mc_i_opcode = 6'b000010;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("t6_decode", int'(mc_o_state), 2);
      push(12, 8'b0001_0010, i, 1'b1, i % 4);
      cyc(); chk("t6_jump", int'(mc_o_state), 12);
      chk("t6_jump_pcw_pcsrc", int'({mc_o_PCWrite, mc_o_PCSrc}), 3'b110);
      cyc(); chk("t6_retired_w2", int'(r2_retired), (i + 1) % 4);
    end
    chk("t6_retired_w16", int'(mc_o_retired), 5);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
